exec_sequencer: RTL

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

---
 rtl/exec_seq_pkg.sv | 59 +++++
 rtl/exec_seq_if.sv | 23 ++
 rtl/seq_decode.sv | 35 +++
 rtl/exec_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/exec_seq_pkg.sv
// Shared constants for the instruction sequencer: state codes, opcodes,
// H4 function codes, strobe bit positions and the multiply cycle count.
package exec_seq_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_F_ADDR  = 3'd1;
  localparam logic [2:0] S_F_WAIT  = 3'd2;
  localparam logic [2:0] S_PC_INC  = 3'd3;
  localparam logic [2:0] S_LD_B    = 3'd4;
  localparam logic [2:0] S_EXEC    = 3'd5;
  localparam logic [2:0] S_MUL_RUN = 3'd6;
  localparam logic [2:0] S_HALT    = 3'd7;

  localparam logic [3:0] OP_MOV = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_CMP = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;

  typedef enum logic [2:0] {
    ALU_PASS_A = 3'd0,
    ALU_ADD    = 3'd1,
    ALU_SUB    = 3'd2,
    ALU_AND    = 3'd3,
    ALU_OR     = 3'd4,
    ALU_XOR    = 3'd5,
    ALU_INC_A  = 3'd6
  } alu_fn_e;

  // ctl = {SB0,B0B,MMD,MDA,SMA,SHS,ALS_H4,EX0}
  localparam int CTL_EX0    = 0;
  localparam int CTL_ALS_H4 = 1;
  localparam int CTL_SHS    = 2;
  localparam int CTL_SMA    = 3;
  localparam int CTL_MDA    = 4;
  localparam int CTL_MMD    = 5;
  localparam int CTL_B0B    = 6;
  localparam int CTL_SB0    = 7;

  // op_flags = {MOV,ADD,SUB,CMP,AND,OR,XOR,MUL3}
  localparam int FLG_MUL3 = 0;
  localparam int FLG_XOR  = 1;
  localparam int FLG_OR   = 2;
  localparam int FLG_AND  = 3;
  localparam int FLG_CMP  = 4;
  localparam int FLG_SUB  = 5;
  localparam int FLG_ADD  = 6;
  localparam int FLG_MOV  = 7;

  localparam int MUL_CYCLES = 16;

  function automatic logic [7:0] onehot8(input logic [2:0] sel);
    onehot8 = 8'h01 << sel;
  endfunction

endpackage

// File: rtl/exec_seq_if.sv
// Sequencer-side bundle: run/memory inputs and the registered strobe outputs.
interface exec_seq_if;
  logic        run;
  logic        mem_ready;
  logic [15:0] instr_in;
  logic [7:0]  ra_sel;
  logic [7:0]  sr_sel;
  logic [7:0]  ctl;
  logic [2:0]  alu_fn;
  logic [7:0]  op_flags;
  logic        busy;
  logic        illegal;

  modport master (
    input  run, mem_ready, instr_in,
    output ra_sel, sr_sel, ctl, alu_fn, op_flags, busy, illegal
  );

  modport slave (
    output run, mem_ready, instr_in,
    input  ra_sel, sr_sel, ctl, alu_fn, op_flags, busy, illegal
  );
endinterface

// File: rtl/seq_decode.sv
// Opcode decoder: IR opcode field -> PSW flag, H4 function and class bits.
// Opcode 7 is a legal multiply only when EXEC_SEQ_MUL_EN is defined.
module seq_decode
  import exec_seq_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [7:0] op_flags,
  output logic [2:0] alu_fn,
  output logic       is_cmp,
  output logic       is_mul,
  output logic       is_illegal
);

  always_comb begin
    op_flags   = '0;
    alu_fn     = ALU_PASS_A;
    is_cmp     = 1'b0;
    is_mul     = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_MOV: op_flags[FLG_MOV] = 1'b1;
      OP_ADD: begin op_flags[FLG_ADD] = 1'b1; alu_fn = ALU_ADD; end
      OP_SUB: begin op_flags[FLG_SUB] = 1'b1; alu_fn = ALU_SUB; end
      OP_CMP: begin op_flags[FLG_CMP] = 1'b1; alu_fn = ALU_SUB; is_cmp = 1'b1; end
      OP_AND: begin op_flags[FLG_AND] = 1'b1; alu_fn = ALU_AND; end
      OP_OR:  begin op_flags[FLG_OR]  = 1'b1; alu_fn = ALU_OR;  end
      OP_XOR: begin op_flags[FLG_XOR] = 1'b1; alu_fn = ALU_XOR; end
`ifdef EXEC_SEQ_MUL_EN
      OP_MUL: begin op_flags[FLG_MUL3] = 1'b1; is_mul = 1'b1; end
`endif
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/exec_sequencer.sv
// Moore fetch/execute sequencer driving register-select and datapath strobes.
// Optional multiply sequence is built only with EXEC_SEQ_MUL_EN defined.
//
// state   | meaning
// IDLE    | stopped, waiting for run
// F_ADDR  | PC (R7) onto A bus, shifter to MAR
// F_WAIT  | memory read, latch IR on mem_ready
// PC_INC  | R7 <= R7 + 1
// LD_B    | source register into B0
// EXEC    | H4 op, write dst (no write for CMP)
// MUL_RUN | 16-cycle multiply, write dst on last cycle
// HALT    | undefined opcode seen, exits on reset only
module exec_sequencer
  import exec_seq_pkg::*;
(
  input  logic        CLK,
  input  logic        CLR,
  exec_seq_if.master  bus
);

  logic [2:0]  state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  dec_flags;
  logic [2:0]  dec_alu;
  logic        is_cmp, is_mul, is_illegal;

  logic [7:0]  ra_d, sr_d, ctl_d, flags_d;
  logic [2:0]  alu_d;
  logic        busy_d;
  logic [7:0]  ra_q, sr_q, ctl_q, flags_q;
  logic [2:0]  alu_q;
  logic        busy_q, illegal_q;

`ifdef EXEC_SEQ_MUL_EN
  logic [4:0]  cnt_q, cnt_d;
`else
  logic        unused_is_mul;
  assign unused_is_mul = is_mul;
`endif

  // Decode the next IR so registered outputs line up with the next state.
  seq_decode u_decode (
    .opcode     (ir_d[15:12]),
    .op_flags   (dec_flags),
    .alu_fn     (dec_alu),
    .is_cmp     (is_cmp),
    .is_mul     (is_mul),
    .is_illegal (is_illegal)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
`ifdef EXEC_SEQ_MUL_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE:   if (bus.run) state_d = S_F_ADDR;
      S_F_ADDR: state_d = S_F_WAIT;
      S_F_WAIT: if (bus.mem_ready) begin
        ir_d    = bus.instr_in;
        state_d = S_PC_INC;
      end
      S_PC_INC: state_d = is_illegal ? S_HALT : S_LD_B;
      S_LD_B: begin
`ifdef EXEC_SEQ_MUL_EN
        if (is_mul) begin
          state_d = S_MUL_RUN;
          cnt_d   = 5'(MUL_CYCLES - 1);
        end else
`endif
          state_d = S_EXEC;
      end
      S_EXEC:   state_d = bus.run ? S_F_ADDR : S_IDLE;
`ifdef EXEC_SEQ_MUL_EN
      S_MUL_RUN: begin
        if (cnt_q == 5'd0) state_d = bus.run ? S_F_ADDR : S_IDLE;
        else               cnt_d   = cnt_q - 5'd1;
      end
`endif
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ra_d    = '0;
    sr_d    = '0;
    ctl_d   = '0;
    flags_d = '0;
    alu_d   = ALU_PASS_A;
    busy_d  = (state_d != S_IDLE) && (state_d != S_HALT);
    case (state_d)
      S_F_ADDR: begin
        ra_d           = onehot8(3'd7);
        ctl_d[CTL_SHS] = 1'b1;
        ctl_d[CTL_SMA] = 1'b1;
      end
      S_F_WAIT: ctl_d[CTL_MMD] = 1'b1;
      S_PC_INC: begin
        ra_d              = onehot8(3'd7);
        sr_d              = onehot8(3'd7);
        alu_d             = ALU_INC_A;
        ctl_d[CTL_ALS_H4] = 1'b1;
      end
      S_LD_B: begin
        ra_d           = onehot8(ir_d[8:6]);
        ctl_d[CTL_SHS] = 1'b1;
        ctl_d[CTL_SB0] = 1'b1;
      end
      S_EXEC: begin
        ra_d              = onehot8(ir_d[11:9]);
        sr_d              = is_cmp ? 8'h00 : onehot8(ir_d[11:9]);
        alu_d             = dec_alu;
        flags_d           = dec_flags;
        ctl_d[CTL_B0B]    = 1'b1;
        ctl_d[CTL_ALS_H4] = 1'b1;
        ctl_d[CTL_EX0]    = 1'b1;
      end
`ifdef EXEC_SEQ_MUL_EN
      S_MUL_RUN: begin
        ra_d = onehot8(ir_d[11:9]);
        if (cnt_d == 5'd0) begin
          sr_d           = onehot8(ir_d[11:9]);
          alu_d          = dec_alu;
          flags_d        = dec_flags;
          ctl_d[CTL_EX0] = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      ra_q      <= '0;
      sr_q      <= '0;
      ctl_q     <= '0;
      flags_q   <= '0;
      alu_q     <= '0;
      busy_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      ra_q      <= ra_d;
      sr_q      <= sr_d;
      ctl_q     <= ctl_d;
      flags_q   <= flags_d;
      alu_q     <= alu_d;
      busy_q    <= busy_d;
      illegal_q <= illegal_q | (state_d == S_HALT);
    end
  end

`ifdef EXEC_SEQ_MUL_EN
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`endif

  assign bus.ra_sel   = ra_q;
  assign bus.sr_sel   = sr_q;
  assign bus.ctl      = ctl_q;
  assign bus.alu_fn   = alu_q;
  assign bus.op_flags = flags_q;
  assign bus.busy     = busy_q;
  assign bus.illegal  = illegal_q;

endmodule
